// File: rtl/clock_gen_pkg.sv
// Shared constants and types for the clock divider / startup sequencer.
`timescale 1ns / 1ps
package clock_gen_pkg;

   localparam int CLK_DIV       = 4;
   localparam int PHASE_W       = 2;
   localparam int STARTUP_CNT_W = 8;

   typedef logic [PHASE_W-1:0] phase_t;

   // Phase 0 is the first cycle with clock1x high; phase 3 precedes the rise.
   localparam phase_t PH_RISE     = 2'd0;
   localparam phase_t PH_PRE_RISE = 2'd3;
   localparam phase_t PH_HALF     = phase_t'(CLK_DIV / 2);

   typedef enum logic [1:0] {
      ST_ARM   = 2'd0,   // waiting for the uncounted first wrap
      ST_COUNT = 2'd1,   // counting completed clock1x periods
      ST_DONE  = 2'd2    // startup complete, sticky until reset
   } startup_state_t;

   // clock1x is high for the first half of the divided period.
   function automatic logic is_high_phase(phase_t p);
      return phase_t'(p - PH_RISE) < PH_HALF;
   endfunction

endpackage

// File: rtl/clock_gen_if.sv
// Output bundle of clock_gen: divided clock, phase info and startup status.
`timescale 1ns / 1ps
interface clock_gen_if;
   import clock_gen_pkg::*;

   logic   clock1x;
   phase_t phase;
   logic   strobe_1x;
   logic   ready;
   logic   startup_reset;

   modport master (output clock1x, phase, strobe_1x, ready, startup_reset);
   modport slave  (input  clock1x, phase, strobe_1x, ready, startup_reset);

endinterface

// File: rtl/clock_gen_startup.sv
// Startup sequencer: counts completed clock1x periods after reset release
// and raises a sticky ready once STARTUP_PERIODS of them have elapsed.
`timescale 1ns / 1ps
module clock_gen_startup
   import clock_gen_pkg::*;
#(
   parameter int STARTUP_PERIODS = 4
) (
   input  logic clock4x,
   input  logic global_reset,
   input  logic wrap,
   output logic ready
);

   localparam logic [STARTUP_CNT_W-1:0] TARGET = STARTUP_CNT_W'(STARTUP_PERIODS);
   localparam logic [STARTUP_CNT_W-1:0] ONE    = STARTUP_CNT_W'(1);

   startup_state_t            state_q, state_d;
   logic [STARTUP_CNT_W-1:0]  cnt_q, cnt_d;

   // State, period count and registered ready; reset wins over everything.
   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         state_q <= ST_ARM;
         cnt_q   <= '0;
         ready   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready   <= (state_d == ST_DONE);
      end
   end

   // Skip the first wrap (it is the release itself), then count to TARGET.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_ARM: begin
            if (wrap) state_d = ST_COUNT;
         end
         ST_COUNT: begin
            if (wrap && (cnt_q != '1)) begin
               cnt_d = cnt_q + ONE;
               if (cnt_d == TARGET) state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase
   end

endmodule

// File: rtl/clock_gen.sv
// Divide-by-4 clock generator with phase/strobe outputs and a startup hold.
`timescale 1ns / 1ps
module clock_gen
   import clock_gen_pkg::*;
#(
   parameter int STARTUP_PERIODS = 4
) (
   input  logic        clock4x,
   input  logic        global_reset,
   clock_gen_if.master bus
);

   phase_t phase_q, phase_d;
   logic   clock1x_q;
   logic   ready;
   logic   wrap;

   assign phase_d = phase_q + phase_t'(1);
   assign wrap    = (phase_q == PH_PRE_RISE);

   // Phase counter and glitch-free registered clock1x derived from next phase.
   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         phase_q   <= PH_PRE_RISE;
         clock1x_q <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         clock1x_q <= is_high_phase(phase_d);
      end
   end

   clock_gen_startup #(
      .STARTUP_PERIODS (STARTUP_PERIODS)
   ) u_startup (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .wrap         (wrap),
      .ready        (ready)
   );

   assign bus.clock1x       = clock1x_q;
   assign bus.phase         = phase_q;
   assign bus.strobe_1x     = (phase_q == PH_PRE_RISE);
   assign bus.ready         = ready;
   assign bus.startup_reset = ~ready;

endmodule

// File: tb/tb_clock_gen.sv
// Bench for clock_gen: three instances (4, 1, 255 startup periods) checked
// each cycle against an edge-count model, plus a 40 MHz capture scenario.
`timescale 1ns / 1ps
module tb_clock_gen;

   logic clock4x      = 1'b0;
   logic global_reset = 1'b1;

   always #3.125 clock4x = ~clock4x;

   clock_gen_if b4 ();
   clock_gen_if b1 ();
   clock_gen_if b255 ();

   clock_gen u4 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .bus          (b4)
   );
   clock_gen #(.STARTUP_PERIODS(1)) u1 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .bus          (b1)
   );
   clock_gen #(.STARTUP_PERIODS(255)) u255 (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .bus          (b255)
   );

   int errors = 0;
   int checks = 0;
   int n      = 0;   // edges since reset release; 0 while in reset

   // Model: outputs after edge e as {clock1x, phase, strobe, ready, startup_reset}.
   function automatic logic [5:0] model(int e, int periods);
      int   p;
      logic clk, rdy;
      p   = (e == 0) ? 3 : (e - 1) % 4;
      clk = (e != 0) && (p < 2);
      rdy = (e != 0) && (e >= 4 * periods + 1);
      return {clk, 2'(p), (p == 3), rdy, ~rdy};
   endfunction

   function automatic logic [17:0] exp_all(int e);
      return {model(e, 4), model(e, 1), model(e, 255)};
   endfunction

   function automatic logic [17:0] got_all();
      return {b4.clock1x, b4.phase, b4.strobe_1x, b4.ready, b4.startup_reset,
              b1.clock1x, b1.phase, b1.strobe_1x, b1.ready, b1.startup_reset,
              b255.clock1x, b255.phase, b255.strobe_1x, b255.ready, b255.startup_reset};
   endfunction

   // Advance one clock4x edge and sample 1 ns later.
   task automatic step();
      @(posedge clock4x);
      if (global_reset) n = 0;
      else n++;
      #1;
   endtask

   task automatic test_reset();
      int len;
      len = $urandom_range(2, 3);
      global_reset = 1'b1;
      repeat (len) begin
         step();
         checks++;
         if (got_all() !== exp_all(0)) begin
            errors++;
            $display("FAIL reset_hold: got %b required %b", got_all(), exp_all(0));
         end
      end
      global_reset = 1'b0;
      step();
      checks++;
      if ({b4.clock1x, b4.phase, got_all()} !== {1'b1, 2'd0, exp_all(1)}) begin
         errors++;
         $display("FAIL first_rise: clock1x=%b phase=%0d all=%b required clock1x=1 phase=0 all=%b",
                  b4.clock1x, b4.phase, got_all(), exp_all(1));
      end
   endtask

   task automatic test_free_run_startup();
      int   rises;
      logic prev;
      rises = 0;
      prev  = b4.clock1x;
      while (n < 120) begin
         step();
         checks++;
         if (got_all() !== exp_all(n)) begin
            errors++;
            $display("FAIL run edge=%0d: got %b required %b", n, got_all(), exp_all(n));
         end
         if (n <= 41 && b4.clock1x && !prev) rises++;
         prev = b4.clock1x;
      end
      checks++;
      if (rises !== 10) begin
         errors++;
         $display("FAIL clock1x_rises_edges_2_41: got %0d required 10", rises);
      end
   endtask

   task automatic test_startup_255();
      while (n < 1100) begin
         step();
         checks++;
         if (got_all() !== exp_all(n)) begin
            errors++;
            $display("FAIL long_run edge=%0d: got %b required %b", n, got_all(), exp_all(n));
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int it = 0; it < 3; it++) begin
         int extra, tail;
         extra = $urandom_range(0, 5);
         tail  = $urandom_range(18, 40);
         repeat (extra * 4) step();
         while ((n - 1) % 4 != 1) step();
         global_reset = 1'b1;
         step();
         checks++;
         if (got_all() !== exp_all(0)) begin
            errors++;
            $display("FAIL mid_reset it=%0d: got %b required %b", it, got_all(), exp_all(0));
         end
         global_reset = 1'b0;
         repeat (tail) begin
            step();
            checks++;
            if (got_all() !== exp_all(n)) begin
               errors++;
               $display("FAIL after_mid_reset it=%0d edge=%0d: got %b required %b",
                        it, n, got_all(), exp_all(n));
            end
         end
      end
   endtask

   int      data40;
   realtime t_chg;

   task automatic test_sampling();
      realtime t1, te, d;
      logic    strobe_prev;
      int      caps, cap;
      global_reset = 1'b1;
      step();
      global_reset = 1'b0;
      step();
      t1     = $realtime - 1.0;
      data40 = 0;
      t_chg  = t1 - 12.5;
      // Independent 40 MHz source: changes at 12.5 ns into each 25 ns period.
      fork
         begin
            #11.5;
            repeat (14) begin
               data40++;
               t_chg = $realtime;
               #25;
            end
         end
      join_none
      caps        = 0;
      strobe_prev = b4.strobe_1x;
      repeat (40) begin
         step();
         te = $realtime - 1.0;
         if (strobe_prev) begin
            cap = data40;
            d   = te - t_chg;
            caps++;
            checks++;
            if (((n - 1) % 4 != 0) || (b4.clock1x !== 1'b1) || (d < 6.0) || (d > 19.0)
                || (cap != (n - 1) / 4)) begin
               errors++;
               $display("FAIL capture edge=%0d: clock1x=%b age=%0.3f data=%0d required rise edge, age 6..19, data=%0d",
                        n, b4.clock1x, d, cap, (n - 1) / 4);
            end
         end
         strobe_prev = b4.strobe_1x;
      end
      checks++;
      if (caps !== 10) begin
         errors++;
         $display("FAIL capture_count: got %0d required 10", caps);
      end
   endtask

   initial begin
      test_reset();
      test_free_run_startup();
      test_startup_255();
      test_mid_reset();
      test_sampling();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
